wb_ctrl: RTL and testbench
==========================

# wb_ctrl

Writeback controller and register scoreboard that drives the single write port of the 32×32 register file. It merges single-cycle ALU results and long-latency unit (load/mul-div) results, serializes them onto one write per cycle, and tracks destination registers whose long-latency results are still outstanding. It also forwards the in-flight write to the read side, because the register file reads combinationally and writes at the clock edge.

## Interface
- `XLEN`, 32, data width
- `LU_DEPTH`, 2, entries in the long-latency result FIFO (power of two, ≥2)

- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `issue_valid`  in  1  a long-latency op is issued this cycle
- `issue_rd`  in  5  destination of the issued op
- `alu_valid`  in  1  ALU result present
- `alu_rd`  in  5  ALU destination
- `alu_data`  in  XLEN  ALU result
- `alu_stall`  out  1  ALU result not taken this cycle; upstream holds it
- `lu_valid`  in  1  long-latency result offered
- `lu_ready`  out  1  result accepted when `lu_valid && lu_ready`
- `lu_rd`  in  5  long-latency destination
- `lu_data`  in  XLEN  long-latency result
- `wen`  out  1  register-file write enable (registered)
- `wAddress`  out  5  register-file write address (registered)
- `wdata`  out  XLEN  register-file write data (registered)
- `rs1_addr`, `rs2_addr`  in  5  read addresses being presented to the register file
- `rs1_pending`, `rs2_pending`  out  1  operand still awaiting a long-latency result
- `rs1_fwd`, `rs2_fwd`  out  1  use forwarded data instead of register-file data
- `fwd_data`  out  XLEN  equals `wdata`

## Operation
- Write stage register (`wen`, `wAddress`, `wdata`) is loaded every cycle from the arbitration winner. `wen` is 0 when there is no winner.
- Arbitration order:
  1. If the FIFO is full and holds a head entry, the FIFO head wins and `alu_stall` = `alu_valid && alu_rd!=0`.
  2. Otherwise an ALU result with `alu_rd != 0` wins and `alu_stall` = 0.
  3. Otherwise a non-empty FIFO pops its head.
- ALU results with `alu_rd == 0` are dropped, never stalled, and consume no slot.
- `lu_ready` = FIFO not full (registered occupancy, so it does not depend combinationally on `lu_valid`).
- An accepted result with `lu_rd == 0` is discarded and not enqueued.
- Scoreboard: 32-bit `pending` mask with bit 0 hard-wired to 0.
  - Set on `issue_valid && issue_rd != 0`.
  - Cleared when a FIFO entry with that rd is loaded into the write stage.
  - Set and clear on the same bit in the same cycle: set wins.
  - A clear never affects other bits.
- `rsN_pending` = `pending[rsN_addr]`. It is combinational and 0 for address 0.
- `rsN_fwd` = `wen && wAddress == rsN_addr && rsN_addr != 0`. Forwarding takes effect even when the bit was just cleared.
- ALU results never touch the scoreboard. Issue logic must not let an ALU op target a pending rd; asserting this is the bench's job.

## Timing
- Reset values: `wen`=0, `wAddress`=0, `wdata`=0, FIFO empty, `pending`=0, `lu_ready`=1 (combinationally, from the empty FIFO), `alu_stall`=0, all `*_fwd`=0 and `*_pending`=0.
- Latency:
  - ALU result at cycle N appears on the write port in cycle N+1 and is in the register file from cycle N+2.
  - An accepted long-latency result appears on the write port no earlier than cycle N+2, because it passes through the FIFO.
- FIFO: push and pop in the same cycle on a full FIFO is not allowed, since `lu_ready` is 0 when full. Push and pop on a non-full, non-empty FIFO keeps occupancy unchanged. Read/write pointers wrap modulo `LU_DEPTH`.
- `rst` asserted mid-operation discards FIFO contents, the pending mask and any write in flight in the next cycle. No partial write is issued.

## Structure
- Shared package `rv_pkg`: `XLEN`, `REG_ADDR_W`=5, `NUM_REGS`=32, and a writeback entry typedef {rd, data}.
- One sub-module, `wb_fifo`: a synchronous FIFO with valid/ready, parameterized by depth and entry type. It exposes `full`, `empty`, head entry and `pop`.
- Scoreboard, arbiter and write stage live in `wb_ctrl`.

## Test plan
- Reset, then ALU writes x5=0x1234 in cycle 1 → `wen`=1, `wAddress`=5, `wdata`=0x1234 in cycle 2. `rs1_addr`=5 in cycle 2 → `rs1_fwd`=1, `fwd_data`=0x1234.
- Issue rd=7. Three cycles later an LU result x7=0xCAFE with no ALU traffic → `rs2_pending`(addr 7) is 1 until the write stage loads x7, then 0. Write appears 2 cycles after acceptance.
- Fill the FIFO (2 results) while the ALU is valid every cycle → `lu_ready`=0. Next cycle the FIFO head wins and `alu_stall`=1. The ALU result is written the following cycle once `alu_stall`=0.
- Issue rd=9 in the same cycle the FIFO head for x9 loads the write stage → `pending[9]` remains 1 afterwards.
- ALU rd=0 and LU rd=0 both valid → no write, `alu_stall`=0, `lu_ready` stays 1, FIFO occupancy unchanged. `rs1_addr`=0 → `rs1_pending`=0, `rs1_fwd`=0.
- `rst` pulsed with 2 FIFO entries and pending bits set → next cycle `wen`=0, `pending`=0, `lu_ready`=1. No stale write ever appears.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared register-file widths and writeback entry type
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous valid/ready FIFO holding long-latency results
module wb_fifo
   import rv_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = wb_entry_t
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push_valid,
   output logic   push_ready,
   input  entry_t push_data,
   input  logic   pop,
   output entry_t head,
   output logic   full,
   output logic   empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full       = (count_q == CNT_FULL);
   assign empty      = (count_q == '0);
   assign push_ready = !full;
   assign head       = mem_q[rd_ptr_q];
   assign do_push    = push_valid && !full;
   assign do_pop     = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/wb_ctrl.sv
// rtl/wb_ctrl.sv - writeback arbiter, register scoreboard and write-port forwarding
module wb_ctrl
   import rv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int LU_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   output logic                  alu_stall,
   input  logic                  lu_valid,
   output logic                  lu_ready,
   input  logic [REG_ADDR_W-1:0] lu_rd,
   input  logic [XLEN-1:0]       lu_data,
   output logic                  wen,
   output logic [REG_ADDR_W-1:0] wAddress,
   output logic [XLEN-1:0]       wdata,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic                  rs1_pending,
   output logic                  rs2_pending,
   output logic                  rs1_fwd,
   output logic                  rs2_fwd,
   output logic [XLEN-1:0]       fwd_data
);

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } entry_t;

   entry_t                fifo_push_data, fifo_head, win;
   logic                  fifo_push_valid, fifo_pop, fifo_full, fifo_empty;
   logic                  alu_take, win_valid;
   logic                  wen_q, wen_d;
   logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;
   logic [NUM_REGS-1:0]   pending_q, pending_d;

   // Results for x0 never occupy a slot.
   assign fifo_push_valid = lu_valid && (lu_rd != '0);
   assign fifo_push_data  = '{rd: lu_rd, data: lu_data};

   wb_fifo #(
      .DEPTH   (LU_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (fifo_push_valid),
      .push_ready (lu_ready),
      .push_data  (fifo_push_data),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   assign alu_take = alu_valid && (alu_rd != '0);

   // A full FIFO preempts the ALU so long-latency units can never deadlock.
   always_comb begin
      fifo_pop  = 1'b0;
      alu_stall = 1'b0;
      win_valid = 1'b0;
      win       = '0;
      if (fifo_full) begin
         fifo_pop  = 1'b1;
         win_valid = 1'b1;
         win       = fifo_head;
         alu_stall = alu_take;
      end else if (alu_take) begin
         win_valid = 1'b1;
         win       = '{rd: alu_rd, data: alu_data};
      end else if (!fifo_empty) begin
         fifo_pop  = 1'b1;
         win_valid = 1'b1;
         win       = fifo_head;
      end
   end

   assign wen_d   = win_valid;
   assign waddr_d = win.rd;
   assign wdata_d = win.data;

   // Set is applied after clear so a re-issue in the retiring cycle survives.
   always_comb begin
      pending_d = pending_q;
      if (fifo_pop) pending_d[fifo_head.rd] = 1'b0;
      if (issue_valid && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         pending_q <= '0;
      end else begin
         wen_q     <= wen_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         pending_q <= pending_d;
      end
   end

   assign wen         = wen_q;
   assign wAddress    = waddr_q;
   assign wdata       = wdata_q;
   assign fwd_data    = wdata_q;
   assign rs1_pending = pending_q[rs1_addr];
   assign rs2_pending = pending_q[rs2_addr];
   assign rs1_fwd     = wen_q && (waddr_q == rs1_addr) && (rs1_addr != '0);
   assign rs2_fwd     = wen_q && (waddr_q == rs2_addr) && (rs2_addr != '0);

endmodule

// File: tb/tb_wb_ctrl.sv
// tb/tb_wb_ctrl.sv - directed and randomized checks of wb_ctrl against a queue-based model
module tb_wb_ctrl;

   localparam int LU_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        alu_stall;
   logic        lu_valid = 1'b0;
   logic        lu_ready;
   logic [4:0]  lu_rd = '0;
   logic [31:0] lu_data = '0;
   logic        wen;
   logic [4:0]  wAddress;
   logic [31:0] wdata;
   logic [4:0]  rs1_addr = '0;
   logic [4:0]  rs2_addr = '0;
   logic        rs1_pending, rs2_pending, rs1_fwd, rs2_fwd;
   logic [31:0] fwd_data;

   always #5 clk = ~clk;

   wb_ctrl #(.XLEN(32), .LU_DEPTH(LU_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
      .wen(wen), .wAddress(wAddress), .wdata(wdata),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
      .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .fwd_data(fwd_data)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: pending results as a queue, scoreboard as a bit mask.
   typedef struct {
      bit [4:0]  rd;
      bit [31:0] data;
   } ent_t;

   ent_t      mq[$];
   bit [31:0] mpend;
   bit        mwen;
   bit [4:0]  mwa;
   bit [31:0] mwd;

   task automatic step(input bit iv, input bit [4:0] ird,
                       input bit av, input bit [4:0] ard, input bit [31:0] ad,
                       input bit lv, input bit [4:0] lrd, input bit [31:0] ld,
                       input bit [4:0] r1, input bit [4:0] r2,
                       output bit stalled, output bit accepted);
      bit full, take, win, from_q;
      bit [4:0]  wrd;
      bit [31:0] wd;
      ent_t e;
      @(negedge clk);
      rst = 1'b0;
      issue_valid = iv; issue_rd = ird;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      lu_valid = lv; lu_rd = lrd; lu_data = ld;
      rs1_addr = r1; rs2_addr = r2;
      #1;
      full = (mq.size() == LU_DEPTH);
      take = av && (ard != 0);
      win = 0; from_q = 0; stalled = 0; wrd = 0; wd = 0;
      if (full) begin
         win = 1; from_q = 1; stalled = take;
      end else if (take) begin
         win = 1; wrd = ard; wd = ad;
      end else if (mq.size() > 0) begin
         win = 1; from_q = 1;
      end
      if (from_q) begin
         wrd = mq[0].rd; wd = mq[0].data;
      end
      accepted = lv && !full;
      chk("wen", wen, mwen);
      if (mwen) begin
         chk("waddr", wAddress, mwa);
         chk("wdata", wdata, mwd);
         chk("fwd_data", fwd_data, mwd);
      end
      chk("lu_ready", lu_ready, !full);
      chk("alu_stall", alu_stall, stalled);
      chk("rs1_pending", rs1_pending, (r1 != 0) && mpend[r1]);
      chk("rs2_pending", rs2_pending, (r2 != 0) && mpend[r2]);
      chk("rs1_fwd", rs1_fwd, mwen && (mwa == r1) && (r1 != 0));
      chk("rs2_fwd", rs2_fwd, mwen && (mwa == r2) && (r2 != 0));
      if (take) chk("alu_rd_pending", mpend[ard], 1'b0);
      if (from_q) begin
         mpend[wrd] = 1'b0;
         e = mq.pop_front();
      end
      if (accepted && (lrd != 0)) mq.push_back('{rd: lrd, data: ld});
      if (iv && (ird != 0)) mpend[ird] = 1'b1;
      mwen = win; mwa = wrd; mwd = wd;
   endtask

   task automatic idle(input bit [4:0] r1, input bit [4:0] r2);
      bit s, a;
      step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2, s, a);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      issue_valid = 0; alu_valid = 0; lu_valid = 0;
      @(posedge clk);
      #1;
      mq.delete();
      mpend = '0; mwen = 0; mwa = 0; mwd = 0;
      chk("rst_wen", wen, 1'b0);
      chk("rst_waddr", wAddress, 5'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_lu_ready", lu_ready, 1'b1);
      chk("rst_alu_stall", alu_stall, 1'b0);
   endtask

   function automatic bit [4:0] pick_free();
      bit [4:0] r;
      for (int t = 0; t < 8; t++) begin
         r = 5'($urandom_range(0, 31));
         if (!mpend[r]) return r;
      end
      return 5'd0;
   endfunction

   initial begin
      bit s, a;
      bit alu_hold, lu_hold;
      bit h_av, h_lv, iv;
      bit [4:0]  h_ard, h_lrd, ird, r1, r2;
      bit [31:0] h_ad, h_ld;
      bit [4:0]  iss_q[$];

      do_reset();

      // ALU write and forwarding
      step(0, 0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, s, a);
      step(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, s, a);
      chk("t1_wen", wen, 1'b1);
      chk("t1_waddr", wAddress, 5'd5);
      chk("t1_wdata", wdata, 32'h1234);
      chk("t1_rs1_fwd", rs1_fwd, 1'b1);
      chk("t1_fwd_data", fwd_data, 32'h1234);

      // long-latency result clears its pending bit when written
      step(1, 7, 0, 0, 0, 0, 0, 0, 0, 7, s, a);
      idle(0, 7);
      idle(0, 7);
      step(0, 0, 0, 0, 0, 1, 7, 32'hCAFE, 0, 7, s, a);
      chk("t2_accept_pend", rs2_pending, 1'b1);
      idle(0, 7);
      chk("t2_pop_pend", rs2_pending, 1'b1);
      chk("t2_pop_wen", wen, 1'b0);
      idle(0, 7);
      chk("t2_wen", wen, 1'b1);
      chk("t2_waddr", wAddress, 5'd7);
      chk("t2_wdata", wdata, 32'hCAFE);
      chk("t2_pend_clr", rs2_pending, 1'b0);
      chk("t2_fwd", rs2_fwd, 1'b1);

      // full FIFO preempts the ALU
      step(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, s, a);
      step(1, 11, 0, 0, 0, 0, 0, 0, 0, 0, s, a);
      step(0, 0, 1, 3, 32'h33, 1, 10, 32'hA0, 0, 0, s, a);
      step(0, 0, 1, 4, 32'h44, 1, 11, 32'hB0, 0, 0, s, a);
      step(0, 0, 1, 12, 32'hC0, 0, 0, 0, 0, 0, s, a);
      chk("t3_lu_ready_full", lu_ready, 1'b0);
      chk("t3_stall", alu_stall, 1'b1);
      step(0, 0, 1, 12, 32'hC0, 0, 0, 0, 0, 0, s, a);
      chk("t3_stall_rel", alu_stall, 1'b0);
      chk("t3_head_waddr", wAddress, 5'd10);
      idle(0, 0);
      chk("t3_alu_waddr", wAddress, 5'd12);
      chk("t3_alu_wdata", wdata, 32'hC0);
      idle(0, 0);
      chk("t3_tail_waddr", wAddress, 5'd11);

      // re-issue in the retiring cycle keeps the bit set
      step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, s, a);
      step(0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0, s, a);
      step(1, 9, 0, 0, 0, 0, 0, 0, 9, 0, s, a);
      idle(9, 0);
      chk("t4_waddr", wAddress, 5'd9);
      chk("t4_pend_kept", rs1_pending, 1'b1);

      // x0 traffic is invisible
      step(0, 0, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0, s, a);
      chk("t5_stall", alu_stall, 1'b0);
      chk("t5_lu_ready", lu_ready, 1'b1);
      chk("t5_rs1_pend", rs1_pending, 1'b0);
      chk("t5_rs1_fwd", rs1_fwd, 1'b0);
      idle(0, 0);
      chk("t5_no_write", wen, 1'b0);

      // reset with a full FIFO and pending bits
      step(1, 13, 0, 0, 0, 0, 0, 0, 0, 0, s, a);
      step(1, 14, 0, 0, 0, 0, 0, 0, 0, 0, s, a);
      step(0, 0, 1, 1, 32'h11, 1, 13, 32'hD0, 0, 0, s, a);
      step(0, 0, 1, 2, 32'h22, 1, 14, 32'hE0, 0, 0, s, a);
      do_reset();
      idle(13, 14);
      chk("t6_pend13", rs1_pending, 1'b0);
      chk("t6_pend14", rs2_pending, 1'b0);
      chk("t6_lu_ready", lu_ready, 1'b1);
      for (int i = 0; i < 4; i++) idle(9, 13);

      // randomized traffic respecting the hold and no-pending-ALU-target rules
      alu_hold = 0; lu_hold = 0;
      h_av = 0; h_ard = 0; h_ad = 0; h_lv = 0; h_lrd = 0; h_ld = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!alu_hold) begin
            h_av  = ($urandom_range(0, 1) == 1);
            h_ard = pick_free();
            h_ad  = $urandom;
         end
         iv  = ($urandom_range(0, 3) == 0);
         ird = pick_free();
         if (h_av && (ird == h_ard)) iv = 0;
         if (iv && (ird != 0)) iss_q.push_back(ird);
         if (!lu_hold) begin
            h_ld = $urandom;
            if ((iss_q.size() > 0) && ($urandom_range(0, 9) < 6)) begin
               h_lv = 1; h_lrd = iss_q.pop_front();
            end else if ($urandom_range(0, 15) == 0) begin
               h_lv = 1; h_lrd = 0;
            end else begin
               h_lv = 0; h_lrd = 0;
            end
         end
         r1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 31)) : mwa;
         r2 = 5'($urandom_range(0, 31));
         step(iv, ird, h_av, h_ard, h_ad, h_lv, h_lrd, h_ld, r1, r2, s, a);
         alu_hold = h_av && s;
         lu_hold  = h_lv && !a;
      end

      do_reset();
      idle(0, 0);
      idle(0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
